// File: rtl/sregfile_wb_arbiter.sv
// Write-back arbiter for the scalar register file write port.
// Picks ALU or LSU each cycle, with an anti-starvation bias toward the ALU.
module sregfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [4:0]            alu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_rd_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [4:0]            lsu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_rd_data_i,
  output logic [4:0]            rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  reg_write_en_o,
  output logic                  wb_src_o
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    PRIO_LSU = 1'b0,
    PRIO_ALU = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [CNT_W-1:0]      w_wait_cnt_nxt;
  logic                  w_alu_grant;
  logic                  w_lsu_grant;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  logic [ADDR_W-1:0]     r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_we;
  logic                  r_src;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PRIO_LSU;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next state: an ALU grant resets the bias; each ALU denial counts toward forcing it
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_alu_grant) begin
      w_state_nxt    = PRIO_LSU;
      w_wait_cnt_nxt = '0;
    end else if (alu_valid_i) begin
      if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
        w_state_nxt    = PRIO_ALU;
        w_wait_cnt_nxt = '0;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
      end
    end
  end

  // Grant decode; readies stay low while reset is asserted
  always_comb begin
    w_alu_grant = 1'b0;
    w_lsu_grant = 1'b0;
    if (rst_n) begin
      if (alu_valid_i && (!lsu_valid_i || (r_state == PRIO_ALU))) begin
        w_alu_grant = 1'b1;
      end else if (lsu_valid_i) begin
        w_lsu_grant = 1'b1;
      end
    end
  end

  assign alu_ready_o = w_alu_grant;
  assign lsu_ready_o = w_lsu_grant;
  assign w_sel_addr  = w_alu_grant ? alu_rd_addr_i : lsu_rd_addr_i;
  assign w_sel_data  = w_alu_grant ? alu_rd_data_i : lsu_rd_data_i;

  // Write-port register: x0 updates addr/data but never strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_we      <= 1'b0;
      r_src     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_alu_grant || w_lsu_grant) begin
        r_rd_addr <= w_sel_addr;
        r_rd_data <= w_sel_data;
        r_we      <= (w_sel_addr != '0);
        r_src     <= w_lsu_grant;
      end
    end
  end

  assign rd_addr_o      = r_rd_addr;
  assign rd_data_o      = r_rd_data;
  assign reg_write_en_o = r_we;
  assign wb_src_o       = r_src;

endmodule

// File: tb/tb_sregfile_wb_arbiter.sv
// Self-checking bench for sregfile_wb_arbiter: directed vector table,
// reset corner cases and a randomized run against a behavioural model.
module tb_sregfile_wb_arbiter;

  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_WAIT = 4;
  localparam int          NVEC     = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid_i, lsu_valid_i;
  logic          alu_ready_o, lsu_ready_o;
  logic [4:0]    alu_rd_addr_i, lsu_rd_addr_i, rd_addr_o;
  logic [DW-1:0] alu_rd_data_i, lsu_rd_data_i, rd_data_o;
  logic          reg_write_en_o, wb_src_o;

  int n_tests = 0;
  int n_fail  = 0;

  sregfile_wb_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_addr_i(alu_rd_addr_i), .alu_rd_data_i(alu_rd_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_rd_data_i(lsu_rd_data_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .reg_write_en_o(reg_write_en_o), .wb_src_o(wb_src_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic ear; logic elr;
    logic ewe; logic [4:0] eaddr; logic [31:0] edata; logic esrc;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic ear, input logic elr, input logic ewe,
                              input logic [4:0] eaddr, input logic [31:0] edata, input logic esrc);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.ear = ear; v.elr = elr; v.ewe = ewe; v.eaddr = eaddr; v.edata = edata; v.esrc = esrc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic src);
    check({tag, ".we"},   32'(reg_write_en_o), 32'(we));
    check({tag, ".addr"}, 32'(rd_addr_o),      32'(a));
    check({tag, ".data"}, rd_data_o,           d);
    check({tag, ".src"},  32'(wb_src_o),       32'(src));
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    alu_valid_i = av; alu_rd_addr_i = aa; alu_rd_data_i = ad;
    lsu_valid_i = lv; lsu_rd_addr_i = la; lsu_rd_data_i = ld;
  endtask

  task automatic do_reset_release();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Behavioural model: who wins, how many times ALU has been passed over
  bit          m_alu_first;
  int          m_denials;
  logic        m_we, m_src;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  logic        ra_v, rl_v;
  logic [4:0]  ra_a, rl_a;
  logic [31:0] ra_d, rl_d;
  logic        exp_ar, exp_lr;

  initial begin
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    #2;
    check_outs("por", 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, starting from PRIO_LSU with an empty counter
    tbl[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,   1, 0, 1, 5'd5, 32'hDEADBEEF, 0);
    tbl[1]  = mk(1, 5'd3, 32'h33,       1, 5'd7, 32'h77,  0, 1, 1, 5'd7, 32'h77, 1);
    tbl[2]  = mk(1, 5'd3, 32'h33,       0, 5'd0, 32'h0,   1, 0, 1, 5'd3, 32'h33, 0);
    tbl[3]  = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'h1234, 0, 1, 0, 5'd0, 32'h1234, 1);
    tbl[4]  = mk(0, 5'd0, 32'h0,        1, 5'd9, 32'h99,  0, 1, 1, 5'd9, 32'h99, 1);
    tbl[5]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,   0, 0, 0, 5'd9, 32'h99, 1);
    tbl[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,   0, 0, 0, 5'd9, 32'h99, 1);
    tbl[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,   0, 0, 0, 5'd9, 32'h99, 1);
    tbl[8]  = mk(1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,  0, 1, 1, 5'd2, 32'hB2, 1);
    tbl[9]  = mk(1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,  0, 1, 1, 5'd2, 32'hB2, 1);
    tbl[10] = mk(1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,  0, 1, 1, 5'd2, 32'hB2, 1);
    tbl[11] = mk(1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,  0, 1, 1, 5'd2, 32'hB2, 1);
    tbl[12] = mk(1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,  1, 0, 1, 5'd1, 32'hA1, 0);
    tbl[13] = mk(1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,  0, 1, 1, 5'd2, 32'hB2, 1);
    tbl[14] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,   0, 0, 0, 5'd2, 32'hB2, 1);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld);
      #2;
      check($sformatf("vec%0d.alu_ready", i), 32'(alu_ready_o), 32'(tbl[i].ear));
      check($sformatf("vec%0d.lsu_ready", i), 32'(lsu_ready_o), 32'(tbl[i].elr));
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), tbl[i].ewe, tbl[i].eaddr, tbl[i].edata, tbl[i].esrc);
    end

    // Reset mid-cycle while a strobe is showing and both producers are valid
    drive(1, 5'd6, 32'h66, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    check_outs("pre_rst", 1'b1, 5'd6, 32'h66, 1'b0);
    drive(1, 5'd4, 32'h44, 1, 5'd8, 32'h88);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("mid_rst", 1'b0, 5'd0, 32'd0, 1'b0);
    check("mid_rst.alu_ready", 32'(alu_ready_o), 32'd0);
    check("mid_rst.lsu_ready", 32'(lsu_ready_o), 32'd0);
    @(posedge clk); #1;
    check_outs("in_rst", 1'b0, 5'd0, 32'd0, 1'b0);
    do_reset_release();
    check_outs("post_rst", 1'b0, 5'd0, 32'd0, 1'b0);

    // Randomized traffic against the model
    m_alu_first = 0; m_denials = 0;
    m_we = 0; m_src = 0; m_addr = 5'd0; m_data = 32'd0;
    ra_v = 0; rl_v = 0; ra_a = 0; rl_a = 0; ra_d = 0; rl_d = 0;
    for (int c = 0; c < 400; c++) begin
      if (!ra_v && ($urandom_range(0, 9) < 6)) begin
        ra_v = 1; ra_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom); ra_d = $urandom;
      end
      if (!rl_v && ($urandom_range(0, 9) < 8)) begin
        rl_v = 1; rl_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom); rl_d = $urandom;
      end
      exp_ar = ra_v && (!rl_v || m_alu_first);
      exp_lr = rl_v && !exp_ar;
      drive(ra_v, ra_a, ra_d, rl_v, rl_a, rl_d);
      #2;
      check($sformatf("rnd%0d.alu_ready", c), 32'(alu_ready_o), 32'(exp_ar));
      check($sformatf("rnd%0d.lsu_ready", c), 32'(lsu_ready_o), 32'(exp_lr));
      @(posedge clk);
      if (exp_ar) begin
        m_addr = ra_a; m_data = ra_d; m_we = (ra_a != 0); m_src = 0;
        m_denials = 0; m_alu_first = 0; ra_v = 0;
      end else begin
        if (ra_v) begin
          m_denials++;
          if (m_denials == MAX_WAIT) begin
            m_alu_first = 1; m_denials = 0;
          end
        end
        if (exp_lr) begin
          m_addr = rl_a; m_data = rl_d; m_we = (rl_a != 0); m_src = 1;
        end else begin
          m_we = 0;
        end
      end
      if (exp_lr) rl_v = 0;
      #1;
      check_outs($sformatf("rnd%0d", c), m_we, m_addr, m_data, m_src);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
